// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/EXEC/MEM/WB, gates the
// decoder control word into one-state strobes, tracks wait-state timeouts and retires.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             stop,
  input  logic [3:0]       opcode,
  input  logic             dec_we,
  input  logic             dec_mwe,
  input  logic             dec_outld,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_ld,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             out_ld,
  output logic             pc_ld,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1110;
  localparam int         WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [WAIT_W-1:0]  w_wait_next;
  logic [CNT_W-1:0]   r_count;
  logic               w_timeout;

  assign w_timeout = (r_wait == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (pc_ld)
        r_count <= r_count + 1'b1;
    end
  end

  // The wait counter defaults to zero, so it is cleared on every entry to
  // FETCH/MEM and only advances while a memory access is still stalled.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = '0;
    imem_req     = 1'b0;
    ir_ld        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    out_ld       = 1'b0;
    pc_ld        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run)
          w_state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_ld        = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_ERROR;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_DECODE: begin
        w_state_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE)
          w_state_next = S_MEM;
        else
          w_state_next = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mwe;
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_ld        = 1'b1;
            w_state_next = stop ? S_IDLE : S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (w_timeout) begin
          w_state_next = S_ERROR;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_WB: begin
        rf_we        = dec_we;
        out_ld       = dec_outld;
        pc_ld        = 1'b1;
        w_state_next = (stop || !run) ? S_IDLE : S_FETCH;
      end
      S_HALT:  w_state_next = S_HALT;
      S_ERROR: w_state_next = S_ERROR;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign state       = r_state;
  assign halted      = (r_state == S_HALT);
  assign err         = (r_state == S_ERROR);
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level model builds the expected
// per-cycle outputs from latency rules; a negedge process compares two DUTs.
module tb_multicycle_sequencer;

  localparam int TO = 16;

  logic clk, rst_n, run, stop;
  logic [3:0] opcode;
  logic dec_we, dec_mwe, dec_outld, imem_ready, dmem_ready;

  logic imem_req_a, ir_ld_a, dmem_req_a, dmem_we_a, rf_we_a, out_ld_a, pc_ld_a, halted_a, err_a;
  logic [2:0] state_a;
  logic [15:0] cnt_a;
  logic imem_req_b, ir_ld_b, dmem_req_b, dmem_we_b, rf_we_b, out_ld_b, pc_ld_b, halted_b, err_b;
  logic [2:0] state_b;
  logic [3:0] cnt_b;

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .stop(stop), .opcode(opcode),
    .dec_we(dec_we), .dec_mwe(dec_mwe), .dec_outld(dec_outld),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req_a), .ir_ld(ir_ld_a), .dmem_req(dmem_req_a), .dmem_we(dmem_we_a),
    .rf_we(rf_we_a), .out_ld(out_ld_a), .pc_ld(pc_ld_a), .state(state_a),
    .halted(halted_a), .err(err_a), .instr_count(cnt_a)
  );

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .stop(stop), .opcode(opcode),
    .dec_we(dec_we), .dec_mwe(dec_mwe), .dec_outld(dec_outld),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req_b), .ir_ld(ir_ld_b), .dmem_req(dmem_req_b), .dmem_we(dmem_we_b),
    .rf_we(rf_we_b), .out_ld(out_ld_b), .pc_ld(pc_ld_b), .state(state_b),
    .halted(halted_b), .err(err_b), .instr_count(cnt_b)
  );

  logic [11:0] vec_a, vec_b;
  assign vec_a = {state_a, imem_req_a, ir_ld_a, dmem_req_a, dmem_we_a, rf_we_a, out_ld_a, pc_ld_a, halted_a, err_a};
  assign vec_b = {state_b, imem_req_b, ir_ld_b, dmem_req_b, dmem_we_b, rf_we_b, out_ld_b, pc_ld_b, halted_b, err_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lit_t;

  lit_t        lit_q[$];
  lit_t        cur_lit;
  logic [11:0] exp_vec;
  int          exp_cnt;
  bit          chk_en;
  int          n_tests;
  int          n_fail;
  int          ncyc;
  bit          ab;

  // Single checker: per-cycle model comparison plus queued literal checks.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests += 4;
      if (vec_a !== exp_vec) begin
        n_fail++;
        $display("FAIL outputs_w16 t=%0t got %h expected %h", $time, vec_a, exp_vec);
      end
      if (vec_b !== exp_vec) begin
        n_fail++;
        $display("FAIL outputs_w4 t=%0t got %h expected %h", $time, vec_b, exp_vec);
      end
      if (cnt_a !== exp_cnt[15:0]) begin
        n_fail++;
        $display("FAIL count_w16 t=%0t got %0d expected %0d", $time, cnt_a, exp_cnt[15:0]);
      end
      if (cnt_b !== exp_cnt[3:0]) begin
        n_fail++;
        $display("FAIL count_w4 t=%0t got %0d expected %0d", $time, cnt_b, exp_cnt[3:0]);
      end
    end
    while (lit_q.size() > 0) begin
      cur_lit = lit_q.pop_front();
      n_tests++;
      if (cur_lit.act != cur_lit.exp) begin
        n_fail++;
        $display("FAIL %s got %0d expected %0d", cur_lit.name, cur_lit.act, cur_lit.exp);
      end
    end
  end

  task automatic lit(input string n, input int a, input int e);
    lit_q.push_back('{n, a, e});
  endtask

  // One clock of expectation: HALT/ERROR flags follow the state, retire bumps the count.
  task automatic cyc(input logic [2:0] st, input logic ireq, irld, dreq, dwe, rfwe, ol, pcld);
    exp_vec = {st, ireq, irld, dreq, dwe, rfwe, ol, pcld, st == 3'd6, st == 3'd7};
    @(posedge clk);
    #1;
    if (pcld) exp_cnt++;
    ncyc++;
  endtask

  task automatic idle_cycle(input bit r);
    run = r;
    stop = 1'b0;
    cyc(3'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sticky_cycles(input logic [2:0] st, input int n);
    run = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    for (int i = 0; i < n; i++) cyc(st, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // iw/dw: wait cycles before ready (>= TO never readies); noise drives run=0,
  // stop=1 and irrelevant readies mid-instruction, all of which must be ignored.
  task automatic instr(input logic [3:0] op, input bit we, mwe, ol,
                       input int iw, dw, input bit stp, rn, noise);
    bit is_ld, is_st, last;
    opcode = op; dec_we = we; dec_mwe = mwe; dec_outld = ol;
    run = !noise; stop = noise; dmem_ready = noise;
    ab = 1'b0;
    is_ld = (op == 4'b0111);
    is_st = (op == 4'b1000);
    for (int i = 0; i <= iw && i < TO; i++) begin
      imem_ready = (i == iw);
      cyc(3'd1, 1, i == iw, 0, 0, 0, 0, 0);
    end
    if (iw >= TO) begin ab = 1'b1; return; end
    imem_ready = noise;
    cyc(3'd2, 0, 0, 0, 0, 0, 0, 0);
    if (op == 4'b1110) begin ab = 1'b1; return; end
    cyc(3'd3, 0, 0, 0, 0, 0, 0, 0);
    if (is_ld || is_st) begin
      for (int j = 0; j <= dw && j < TO; j++) begin
        last = (j == dw);
        dmem_ready = last;
        if (last) begin stop = stp; run = rn; end
        cyc(3'd4, 0, 0, 1, mwe, 0, 0, is_st && last);
      end
      if (dw >= TO) begin ab = 1'b1; return; end
    end
    dmem_ready = noise;
    if (!is_st) begin
      stop = stp; run = rn;
      cyc(3'd5, 0, 0, 0, 0, we, ol, 1);
    end
  endtask

  // Reset asserted mid-cycle: outputs must collapse before the next clock edge.
  task automatic do_reset();
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_reset_outputs_w16", int'(vec_a), 0);
    lit("async_reset_outputs_w4", int'(vec_b), 0);
    lit("async_reset_count", int'(cnt_a), 0);
    run = 0; stop = 0; imem_ready = 0; dmem_ready = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_vec = '0;
    chk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    rst_n = 0; run = 0; stop = 0; opcode = 0; dec_we = 0; dec_mwe = 0; dec_outld = 0;
    imem_ready = 0; dmem_ready = 0;
    chk_en = 0; n_tests = 0; n_fail = 0; ncyc = 0; exp_cnt = 0; exp_vec = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back ALU instructions: 4 cycles each
    do_reset();
    idle_cycle(1);
    c0 = ncyc;
    for (int k = 0; k < 3; k++) instr(4'b0000, 1, 0, 0, 0, 0, 0, 1, 0);
    lit("alu_x3_cycles", ncyc - c0, 12);
    lit("alu_x3_count", int'(cnt_a), 3);

    // Load with 3 data wait cycles, mid-instruction run/stop noise ignored
    c0 = ncyc;
    instr(4'b0111, 1, 0, 0, 0, 3, 0, 1, 1);
    lit("load_wait3_cycles", ncyc - c0, 8);

    // Store: retires in MEM
    c0 = ncyc;
    instr(4'b1000, 0, 1, 0, 0, 0, 0, 1, 0);
    lit("store_cycles", ncyc - c0, 4);
    instr(4'b0011, 0, 0, 1, 2, 0, 0, 1, 0);
    instr(4'b1000, 1, 1, 0, 0, 1, 1, 0, 0);
    idle_cycle(0);
    idle_cycle(0);
    lit("count_after_store_stop", int'(cnt_a), 7);

    // Fetch timeout boundary: ready at TIMEOUT-1 accepted, never-ready errors
    idle_cycle(1);
    instr(4'b0001, 1, 0, 0, TO - 1, 0, 0, 1, 0);
    instr(4'b0001, 1, 0, 0, TO, 0, 0, 1, 0);
    lit("fetch_timeout_aborted", int'(ab), 1);
    sticky_cycles(3'd7, 3);
    lit("err_sticky", int'(err_a), 1);
    do_reset();

    // Data memory timeout
    idle_cycle(1);
    instr(4'b0111, 1, 0, 0, 0, TO, 0, 1, 0);
    sticky_cycles(3'd7, 2);
    do_reset();

    // HALT: no retire, reset mid-HALT
    idle_cycle(1);
    instr(4'b0000, 1, 0, 0, 0, 0, 0, 1, 0);
    instr(4'b1110, 1, 0, 1, 0, 0, 0, 1, 0);
    sticky_cycles(3'd6, 4);
    lit("halt_count_unchanged", int'(cnt_a), 1);
    lit("halted_flag", int'(halted_a), 1);
    do_reset();

    // stop at retire of the 2nd instruction, then run=0 at retire
    idle_cycle(1);
    instr(4'b0010, 1, 0, 0, 0, 0, 0, 1, 0);
    instr(4'b0010, 1, 0, 0, 0, 0, 1, 1, 0);
    idle_cycle(0);
    lit("stop_count", int'(cnt_a), 2);
    idle_cycle(1);
    instr(4'b0100, 0, 0, 1, 0, 0, 0, 0, 0);
    idle_cycle(0);

    // 17 retires: 4-bit counter wraps to 1
    do_reset();
    idle_cycle(1);
    for (int k = 0; k < 17; k++) begin
      case (k % 4)
        0: instr(4'b0000, 1, 0, 0, 0, 0, 0, 1, 0);
        1: instr(4'b0111, 1, 0, 0, 0, k % 3, 0, 1, 0);
        2: instr(4'b1000, 0, 1, 0, 0, 0, 0, 1, 0);
        default: instr(4'b0101, 0, 0, 1, 1, 0, 0, 1, 0);
      endcase
    end
    lit("wrap_count_w4", int'(cnt_b), 1);
    lit("wrap_count_w16", int'(cnt_a), 17);
    chk_en = 1'b0;

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
